// File: rtl/edge_event_arbiter_pkg.sv
// Shared types and helpers for the edge event arbiter.
// Holds the grant FSM state encoding and the grant-index width derivation.
package edge_event_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    COOL  = 2'd2
  } state_t;

  // Grant index width: at least one bit even for two channels.
  function automatic int idw_of(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Valid/ready grant port between the arbiter (master) and its single consumer (slave).
interface edge_event_arbiter_if #(
  parameter int IDW = 2
);
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           grant_ready;

  modport master (output grant_valid, output grant_id, input grant_ready);
  modport slave  (input grant_valid, input grant_id, output grant_ready);
endinterface

// File: rtl/edge_event_arbiter_rr_pick.sv
// Combinational round-robin pick: first set pending bit at or above ptr, wrapping at N.
module edge_event_arbiter_rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   pending,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] index
);
  logic [2*N-1:0] rotated;
  logic [IDW:0]   sum;

  // Rotating a doubled copy puts channel ptr at bit 0, so the search is a plain priority scan.
  assign rotated = {pending, pending} >> ptr;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    found = 1'b0;
    index = '0;
    sum   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && rotated[i]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IDW + 1)'(i);
        if (sum >= (IDW + 1)'(N)) sum = sum - (IDW + 1)'(N);
        index = sum[IDW-1:0];
      end
    end
  end
endmodule

// File: rtl/edge_event_arbiter.sv
// Captures rising edges on N level inputs as pending events and grants them one at a
// time to a single consumer, round-robin, with a GAP-cycle cool-down after each accept.
module edge_event_arbiter
  import edge_event_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int GAP = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N-1:0]              entrada,
  input  logic                      ovf_clear,
  output logic [N-1:0]              pending,
  output logic [N-1:0]              overflow,
  edge_event_arbiter_if.master      gnt
);
  localparam int IDW = idw_of(N);
  localparam logic [3:0] COOL_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t         state;
  logic [N-1:0]   prev;
  logic [N-1:0]   rise;
  logic [N-1:0]   accept_vec;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant_id_q;
  logic           grant_valid_q;
  logic [3:0]     cool_cnt;
  logic           accept;
  logic           found;
  logic [IDW-1:0] pick_idx;

  assign rise   = entrada & ~prev;
  assign accept = (state == GRANT) && gnt.grant_ready;

  always_comb begin
    accept_vec = '0;
    for (int i = 0; i < N; i++)
      accept_vec[i] = accept && (grant_id_q == IDW'(i));
  end

  edge_event_arbiter_rr_pick #(.N(N), .IDW(IDW)) u_rr_pick (
    .pending (pending),
    .ptr     (ptr),
    .found   (found),
    .index   (pick_idx)
  );

  // Event capture: a new edge beats the accept clear, and only a truly lost edge marks overflow.
  // NOTE: all state is reset asynchronously and updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= '0;
      pending  <= '0;
      overflow <= '0;
    end else begin
      prev     <= entrada;
      pending  <= (pending & ~accept_vec) | rise;
      overflow <= (ovf_clear ? '0 : overflow) | (rise & pending & ~accept_vec);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      ptr           <= '0;
      cool_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_id_q    <= pick_idx;
            grant_valid_q <= 1'b1;
            state         <= GRANT;
          end
        end
        GRANT: begin
          if (gnt.grant_ready) begin
            grant_valid_q <= 1'b0;
            ptr           <= (grant_id_q == IDW'(N - 1)) ? '0 : grant_id_q + 1'b1;
            cool_cnt      <= '0;
            state         <= (GAP > 0) ? COOL : IDLE;
          end
        end
        COOL: begin
          if (cool_cnt == COOL_LAST) state <= IDLE;
          else                       cool_cnt <= cool_cnt + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gnt.grant_valid = grant_valid_q;
  assign gnt.grant_id    = grant_id_q;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter (N=4, GAP=2): vector table plus hand-written
// reset sequences; expected values are worked out by hand from the behaviour description.
module tb_edge_event_arbiter;
  logic       clk;
  logic       rst_n;
  logic [3:0] entrada;
  logic       ovf_clear;
  logic [3:0] pending;
  logic [3:0] overflow;

  int vec_count;
  int err_count;

  edge_event_arbiter_if #(.IDW(2)) gif ();

  edge_event_arbiter #(.N(4), .GAP(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .entrada   (entrada),
    .ovf_clear (ovf_clear),
    .pending   (pending),
    .overflow  (overflow),
    .gnt       (gif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] entrada;
    logic       ready;
    logic       clr;
    logic       exp_valid;
    logic [1:0] exp_id;
    logic [3:0] exp_pend;
    logic [3:0] exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] e, input logic r, input logic c, input logic v,
                     input logic [1:0] id, input logic [3:0] p, input logic [3:0] o);
    vec_t t;
    t.entrada = e; t.ready = r; t.clr = c;
    t.exp_valid = v; t.exp_id = id; t.exp_pend = p; t.exp_ovf = o;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vec_count++;
    if (act !== exp) begin
      err_count++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic v, input logic [1:0] id,
                               input logic [3:0] p, input logic [3:0] o);
    check($sformatf("%s valid", tag), {7'd0, gif.grant_valid}, {7'd0, v});
    check($sformatf("%s id", tag), {6'd0, gif.grant_id}, {6'd0, id});
    check($sformatf("%s pending", tag), {4'd0, pending}, {4'd0, p});
    check($sformatf("%s overflow", tag), {4'd0, overflow}, {4'd0, o});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_count = 0;
    err_count = 0;

    //   entrada  rdy  clr  valid id  pending  overflow
    // Inputs high across reset release: four edges at once, drained 0,1,2,3.
    add(4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1111, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b1111, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1110, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1110, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1110, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b1110, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b1100, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b1100, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b1100, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b1100, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b1000, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b1000, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b1000, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000);
    // Simultaneous edges on 0,1,3: grants 0,1,3 with three idle cycles between valids.
    add(4'b1011, 1'b1, 1'b0, 1'b0, 2'd3, 4'b1011, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b1011, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1010, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1010, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1010, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b1010, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b1000, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b1000, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b1000, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000);
    // Fairness: ch0 and ch3 raised during cool-down; pointer wrapped to 0 so ch0 first.
    add(4'b1001, 1'b1, 1'b0, 1'b0, 2'd3, 4'b1001, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 4'b1001, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b1001, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1000, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1000, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1000, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000);
    // Single event on ch2: valid two edges after the sampled edge, one cycle wide.
    add(4'b0100, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0100, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0000);
    // Backpressure: repeated edge on the held ch1 grant overflows; edge on accept does not.
    add(4'b0010, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0010, 4'b0000);
    add(4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0000);
    add(4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0010);
    add(4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0010);
    add(4'b0010, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0010, 4'b0010);
    add(4'b0000, 1'b1, 1'b1, 1'b0, 2'd1, 4'b0010, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0010, 4'b0000);
    add(4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0000);
    add(4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0000);
    // Overflow set and ovf_clear in the same cycle: set wins.
    add(4'b0010, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0010, 4'b0010);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 4'b0010);
    add(4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0000, 4'b0000);
    add(4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 4'b0000);

    // Reset held with all inputs high: everything reads zero.
    rst_n           = 1'b0;
    entrada         = 4'b1111;
    ovf_clear       = 1'b0;
    gif.grant_ready = 1'b0;
    tick();
    tick();
    check_outputs("reset", 1'b0, 2'd0, 4'b0000, 4'b0000);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      entrada         = vecs[k].entrada;
      gif.grant_ready = vecs[k].ready;
      ovf_clear       = vecs[k].clr;
      tick();
      check_outputs($sformatf("vec%0d", k), vecs[k].exp_valid, vecs[k].exp_id,
                    vecs[k].exp_pend, vecs[k].exp_ovf);
    end

    // Mid-grant reset: grant on ch3 (pointer at 2) is dropped without waiting for a clock.
    entrada         = 4'b1000;
    gif.grant_ready = 1'b0;
    ovf_clear       = 1'b0;
    tick();
    entrada = 4'b0000;
    tick();
    check_outputs("pre_reset", 1'b1, 2'd3, 4'b1000, 4'b0000);
    #2 rst_n = 1'b0;
    #1;
    check_outputs("async_reset", 1'b0, 2'd0, 4'b0000, 4'b0000);
    #1 rst_n = 1'b1;
    tick();
    check_outputs("post_reset", 1'b0, 2'd0, 4'b0000, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end
endmodule
